// File: rtl/frame_composer.sv
// Per-frame aux shadow fetch plus registered char/figure/background pixel composer.
// Optional blink support is compiled in with `define FRAME_COMPOSER_BLINK_EN.
module frame_composer #(
  parameter int WIDTH             = 640,
  parameter int HEIGHT            = 480,
  parameter int WIDTH_BITS        = 10,
  parameter int HEIGHT_BITS       = 10,
  parameter int DATA_WIDTH        = 16,
  parameter int AUX_ADDRESS_WIDTH = 5,
  parameter int AUX_ELEMENTS      = 8,
  parameter int COLOR_BITS        = 4
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [WIDTH_BITS-1:0]        pixel_x_in,
  input  logic [HEIGHT_BITS-1:0]       pixel_y_in,
  input  logic                         video_on_in,
  input  logic                         v_sync_in,
  input  logic                         char_bit_in,
  input  logic                         figure_bit_in,
  input  logic [DATA_WIDTH-1:0]        aux_data_in,
  output logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out,
  output logic                         bit_value_out,
  output logic                         video_on_out,
  output logic                         frame_done_out,
  output logic [COLOR_BITS-1:0]        pixel_red_out,
  output logic [COLOR_BITS-1:0]        pixel_green_out,
  output logic [COLOR_BITS-1:0]        pixel_blue_out
);
  localparam int CW = 3 * COLOR_BITS;
  localparam logic [AUX_ADDRESS_WIDTH-1:0] LAST_ADDR = AUX_ADDRESS_WIDTH'(AUX_ELEMENTS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LAST, COMMIT} state_t;

  function automatic logic [DATA_WIDTH-1:0] word_default(input int k);
    case (k)
      0:       word_default = DATA_WIDTH'(12'hFFF);
      2:       word_default = DATA_WIDTH'(12'h0F0);
      3:       word_default = DATA_WIDTH'(16'h0003);
      default: word_default = '0;
    endcase
  endfunction

  state_t                       state_q, state_d;
  logic [AUX_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                         vsync_prev_q, vsync_prev_d;
  logic [DATA_WIDTH-1:0]        staging_q [AUX_ELEMENTS];
  logic [DATA_WIDTH-1:0]        staging_d [AUX_ELEMENTS];
  logic [DATA_WIDTH-1:0]        active_q  [AUX_ELEMENTS];
  logic [DATA_WIDTH-1:0]        active_d  [AUX_ELEMENTS];
  logic [CW-1:0]                rgb_q, rgb_d;
  logic                         video_on_q, video_on_d;
  logic                         vsync_fall;
  logic                         char_hide;
  logic                         unused_bits;
`ifdef FRAME_COMPOSER_BLINK_EN
  logic [5:0]                   blink_cnt_q, blink_cnt_d;
`endif

  assign vsync_fall   = vsync_prev_q & ~v_sync_in;
  assign vsync_prev_d = v_sync_in;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    staging_d = staging_q;
    active_d  = active_q;
`ifdef FRAME_COMPOSER_BLINK_EN
    blink_cnt_d = blink_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (vsync_fall) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: begin
        // Read data lags the address by one cycle, so word k lands while address k+1 is out.
        for (int k = 0; k < AUX_ELEMENTS - 1; k++) begin
          if (addr_q == AUX_ADDRESS_WIDTH'(k + 1)) staging_d[k] = aux_data_in;
        end
        if (addr_q == LAST_ADDR) state_d = LAST;
        else                     addr_d  = addr_q + 1'b1;
      end
      LAST: begin
        staging_d[AUX_ELEMENTS-1] = aux_data_in;
        state_d = COMMIT;
        addr_d  = '0;
      end
      COMMIT: begin
        active_d = staging_q;
        state_d  = IDLE;
`ifdef FRAME_COMPOSER_BLINK_EN
        blink_cnt_d = blink_cnt_q + 6'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FRAME_COMPOSER_BLINK_EN
  assign char_hide = active_q[3][4] & blink_cnt_q[5];
`else
  assign char_hide = 1'b0;
`endif

  always_comb begin
    logic [CW-1:0] fg_eff, bg_eff;
    fg_eff     = active_q[3][2] ? active_q[1][CW-1:0] : active_q[0][CW-1:0];
    bg_eff     = active_q[3][2] ? active_q[0][CW-1:0] : active_q[1][CW-1:0];
    video_on_d = video_on_in;
    rgb_d      = '0;
    if (video_on_in) begin
      if (active_q[3][0] && char_bit_in)        rgb_d = char_hide ? bg_eff : fg_eff;
      else if (active_q[3][1] && figure_bit_in) rgb_d = active_q[2][CW-1:0];
      else                                      rgb_d = bg_eff;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      vsync_prev_q <= 1'b1;
      rgb_q        <= '0;
      video_on_q   <= 1'b0;
      for (int k = 0; k < AUX_ELEMENTS; k++) begin
        staging_q[k] <= word_default(k);
        active_q[k]  <= word_default(k);
      end
`ifdef FRAME_COMPOSER_BLINK_EN
      blink_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      vsync_prev_q <= vsync_prev_d;
      rgb_q        <= rgb_d;
      video_on_q   <= video_on_d;
      staging_q    <= staging_d;
      active_q     <= active_d;
`ifdef FRAME_COMPOSER_BLINK_EN
      blink_cnt_q  <= blink_cnt_d;
`endif
    end
  end

  // Reserved words, high colour-word bits and pixel coordinates feed no logic.
  always_comb begin
    unused_bits = ^pixel_x_in ^ ^pixel_y_in;
    for (int k = 0; k < AUX_ELEMENTS; k++) unused_bits = unused_bits ^ (^active_q[k]);
  end

  assign aux_raddress_out = addr_q;
  assign bit_value_out    = active_q[3][3];
  assign video_on_out     = video_on_q;
  assign frame_done_out   = (state_q == COMMIT);
  assign pixel_red_out    = rgb_q[CW-1:2*COLOR_BITS];
  assign pixel_green_out  = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign pixel_blue_out   = rgb_q[COLOR_BITS-1:0];

endmodule

// File: tb/tb_frame_composer.sv
// Directed self-checking bench for frame_composer: reset state, shadow fetch timing,
// colour priority/invert, mid-fetch reset and the 64-frame blink cycle.
module tb_frame_composer;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset_in, video_on_in, v_sync_in, char_bit_in, figure_bit_in;
  logic [9:0]  pixel_x_in, pixel_y_in;
  logic [15:0] aux_data_in;
  logic [4:0]  aux_raddress_out;
  logic        bit_value_out, video_on_out, frame_done_out;
  logic [3:0]  pixel_red_out, pixel_green_out, pixel_blue_out;
  logic [15:0] aux_mem [32];
  logic [11:0] rgb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_composer dut (
    .clock_in(clk), .reset_in(reset_in), .pixel_x_in(pixel_x_in), .pixel_y_in(pixel_y_in),
    .video_on_in(video_on_in), .v_sync_in(v_sync_in), .char_bit_in(char_bit_in),
    .figure_bit_in(figure_bit_in), .aux_data_in(aux_data_in),
    .aux_raddress_out(aux_raddress_out), .bit_value_out(bit_value_out),
    .video_on_out(video_on_out), .frame_done_out(frame_done_out),
    .pixel_red_out(pixel_red_out), .pixel_green_out(pixel_green_out),
    .pixel_blue_out(pixel_blue_out)
  );

  // Aux memory with one cycle of read latency.
  always @(posedge clk) aux_data_in <= aux_mem[aux_raddress_out];

  assign rgb = {pixel_red_out, pixel_green_out, pixel_blue_out};

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pixel(input logic vo, input logic cb, input logic fb, input string tag,
                       input logic [11:0] exp);
    video_on_in = vo; char_bit_in = cb; figure_bit_in = fb;
    tick;
    chk(tag, {4'h0, rgb}, {4'h0, exp});
    video_on_in = 1'b0; char_bit_in = 1'b0; figure_bit_in = 1'b0;
  endtask

  // Full frame with address-sequence and pulse-position checks; glitch adds a second fall mid-fetch.
  task automatic frame_checked(input logic glitch);
    int pulses = 0;
    int first  = 0;
    v_sync_in = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick;
      if (i == 1) v_sync_in = 1'b1;
      if (glitch && i == 3) v_sync_in = 1'b0;
      if (glitch && i == 4) v_sync_in = 1'b1;
      if (i <= N) chk($sformatf("addr_seq_%0d", i - 1), {11'd0, aux_raddress_out}, 16'(i - 1));
      if (frame_done_out) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("frame_done_pulses", 16'(pulses), 16'd1);
    chk("frame_done_latency", 16'(first), 16'(N + 2));
    chk("addr_idle", {11'd0, aux_raddress_out}, 16'd0);
  endtask

  task automatic frame_fast;
    int n = 0;
    v_sync_in = 1'b0;
    tick;
    v_sync_in = 1'b1;
    while (!frame_done_out && n < 20) begin
      tick;
      n++;
    end
    if (!frame_done_out) chk("frame_timeout", 16'd0, 16'd1);
    tick;
  endtask

  initial begin
    int pulses;
    logic [11:0] exp_blink;
    for (int k = 0; k < 32; k++) aux_mem[k] = 16'h0000;
    reset_in = 1'b1; video_on_in = 1'b0; v_sync_in = 1'b1; char_bit_in = 1'b0;
    figure_bit_in = 1'b0; pixel_x_in = '0; pixel_y_in = '0;
    tick; tick; tick;
    chk("reset_rgb", {4'h0, rgb}, 16'h0000);
    chk("reset_video_on", {15'd0, video_on_out}, 16'd0);
    chk("reset_frame_done", {15'd0, frame_done_out}, 16'd0);
    chk("reset_addr", {11'd0, aux_raddress_out}, 16'd0);
    chk("reset_bit_value", {15'd0, bit_value_out}, 16'd0);
    reset_in = 1'b0;
    tick;

    video_on_in = 1'b1; char_bit_in = 1'b1;
    tick;
    chk("default_char_rgb", {4'h0, rgb}, 16'h0FFF);
    chk("video_on_delayed", {15'd0, video_on_out}, 16'd1);
    chk("no_frame_done", {15'd0, frame_done_out}, 16'd0);
    video_on_in = 1'b0; char_bit_in = 1'b0;
    tick;

    aux_mem[0] = 16'h0F00; aux_mem[1] = 16'h0000; aux_mem[2] = 16'h00F0; aux_mem[3] = 16'h0001;
    frame_checked(1'b0);
    pixel(1, 1, 0, "char_red", 12'hF00);
    pixel(1, 0, 1, "fig_disabled_bg", 12'h000);

    aux_mem[3] = 16'h0003;
    frame_checked(1'b1);
    pixel(1, 1, 1, "char_over_fig", 12'hF00);
    pixel(1, 0, 1, "figure_green", 12'h0F0);
    pixel(1, 0, 0, "plain_bg", 12'h000);
    pixel(0, 1, 0, "video_off_black", 12'h000);
    chk("video_on_low", {15'd0, video_on_out}, 16'd0);

    aux_mem[1] = 16'h000F; aux_mem[3] = 16'h000F;
    frame_fast;
    pixel(1, 1, 0, "invert_char_bg", 12'h00F);
    pixel(1, 0, 0, "invert_plain_fg", 12'hF00);
    pixel(1, 0, 1, "invert_figure", 12'h0F0);
    chk("bit_value_set", {15'd0, bit_value_out}, 16'd1);

    // Reset while address 3 is out aborts the fetch.
    v_sync_in = 1'b0;
    tick;
    v_sync_in = 1'b1;
    tick; tick; tick;
    chk("fetch_addr3", {11'd0, aux_raddress_out}, 16'd3);
    reset_in = 1'b1;
    tick;
    chk("abort_addr", {11'd0, aux_raddress_out}, 16'd0);
    chk("abort_frame_done", {15'd0, frame_done_out}, 16'd0);
    reset_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (frame_done_out) pulses++;
    end
    chk("abort_no_pulse", 16'(pulses), 16'd0);
    pixel(1, 1, 0, "abort_word0_default", 12'hFFF);
    chk("abort_bit_value", {15'd0, bit_value_out}, 16'd0);

    aux_mem[0] = 16'h0ABC; aux_mem[1] = 16'h0123; aux_mem[3] = 16'h0011;
    for (int f = 1; f <= 64; f++) begin
      frame_fast;
      if (f == 1 || f == 31 || f == 32 || f == 63 || f == 64) begin
`ifdef FRAME_COMPOSER_BLINK_EN
        exp_blink = (f >= 32 && f <= 63) ? 12'h123 : 12'hABC;
`else
        exp_blink = 12'hABC;
`endif
        pixel(1, 1, 0, $sformatf("blink_frame_%0d", f % 64), exp_blink);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/frame_composer.md
Name: frame_composer

Overview:
- Registered, parametrised successor to frame_generator.
- Snapshots the CPU-written aux register bank into an atomic shadow copy once per frame, during vertical sync. This prevents mid-frame tearing.
- Composes char/figure/background colour per pixel with a fixed 1-cycle pipeline.
- Sits between vga_sync / character_generator / figure_generator and the VGA DAC pins.

Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines
- WIDTH_BITS, 10, pixel_x width
- HEIGHT_BITS, 10, pixel_y width
- DATA_WIDTH, 16, aux word width (must be >= 12)
- AUX_ADDRESS_WIDTH, 5, aux address width
- AUX_ELEMENTS, 8, words fetched per frame (4 <= AUX_ELEMENTS <= 2**AUX_ADDRESS_WIDTH)
- COLOR_BITS, 4, bits per colour channel

Ports:
- clock_in  input  1  pixel clock
- reset_in  input  1  synchronous, active-high reset
- pixel_x_in  input  WIDTH_BITS  current pixel column from vga_sync
- pixel_y_in  input  HEIGHT_BITS  current line from vga_sync
- video_on_in  input  1  visible-area flag from vga_sync
- v_sync_in  input  1  vertical sync, active low
- char_bit_in  input  1  character pixel, same cycle as pixel_x_in
- figure_bit_in  input  1  figure pixel, same cycle as pixel_x_in
- aux_data_in  input  DATA_WIDTH  aux memory read data, 1-cycle latency
- aux_raddress_out  output  AUX_ADDRESS_WIDTH  aux memory read address
- bit_value_out  output  1  glyph polarity to character_generator (active mode[3])
- video_on_out  output  1  video_on_in delayed 1 cycle
- frame_done_out  output  1  1-cycle pulse on shadow commit
- pixel_red_out  output  COLOR_BITS  red channel, registered
- pixel_green_out  output  COLOR_BITS  green channel, registered
- pixel_blue_out  output  COLOR_BITS  blue channel, registered

Behaviour:
- Aux word map (low 3*COLOR_BITS bits = {R,G,B}):
  - word0 = char fg
  - word1 = background
  - word2 = figure colour
  - word3 = mode: bit0 char_en, bit1 fig_en, bit2 invert, bit3 bit_value, bit4 blink_en
  - words 4..AUX_ELEMENTS-1 are fetched but reserved.
- Reset values:
  - active/staging word0 = 12'hFFF, word1 = 0, word2 = 12'h0F0, word3 = 16'h0003; others 0
  - FSM = IDLE; aux_raddress_out = 0
  - all pixel outputs 0; video_on_out = 0; frame_done_out = 0
- Falling-edge detect on v_sync_in uses a registered previous value, which resets to 1.
- FSM states:
  - IDLE: on v_sync fall, go to FETCH with aux_raddress_out = 0.
  - FETCH: aux_raddress_out increments each cycle. Word k is captured into staging[k] on the cycle after address k is presented. After address AUX_ELEMENTS-1 is issued, go to LAST.
  - LAST: capture the final word, go to COMMIT.
  - COMMIT: copy staging to active in one cycle; frame_done_out = 1; aux_raddress_out = 0; return to IDLE.
  - Total: v_sync fall to frame_done_out high = AUX_ELEMENTS+2 cycles.
- A v_sync fall outside IDLE is ignored.
- Reset mid-fetch aborts the fetch: staging and active return to defaults and there is no frame_done_out pulse.
- Pixel pipeline, registered, latency 1 cycle:
  - If video_on_in = 0, output 0.
  - Else if char_en and char_bit_in: fg (bg if invert).
  - Else if fig_en and figure_bit_in: figure colour.
  - Else: bg (fg if invert).
  - Char has priority over figure.
- Colour is taken from the active set only; the active set never changes while video_on_in = 1.
- bit_value_out = active mode[3], combinational from the active register.

Optional Feature:
- Macro: FRAME_COMPOSER_BLINK_EN.
- Defined:
  - 6-bit frame counter, reset 0, increments on each commit and wraps 63->0.
  - When blink_en = 1 and counter[5] = 1, char pixels render as the non-char colour (bg, or fg if invert).
- Undefined: no counter; mode bit4 is ignored.

Test Plan:
- Reset, then video_on_in = 1, char_bit_in = 1, all else 0 -> one cycle later RGB = F,F,F; video_on_out = 1; frame_done_out = 0.
- Aux model returns word0 = 16'h0F00, word3 = 16'h0001; pulse v_sync_in low -> frame_done_out high exactly AUX_ELEMENTS+2 cycles after the fall; char pixel then outputs F,0,0.
- Active set: mode word3 = 16'h0003 (char_en, fig_en). char_bit_in = 1 and figure_bit_in = 1 -> output fg. Next cycle char_bit_in = 0 -> output figure colour 0,F,0. Set word3 = 16'h0007 (invert) -> char pixel outputs bg 0,0,0.
- Hold video_on_in = 0 with char_bit_in = 1 -> RGB 0,0,0. Second v_sync fall during FETCH -> no extra pulse; aux_raddress_out sequence 0..AUX_ELEMENTS-1 is uninterrupted.
- Assert reset_in at FETCH address 3 -> next cycle FSM is IDLE, aux_raddress_out = 0, no frame_done_out, word0 reads back as default 12'hFFF.
- With FRAME_COMPOSER_BLINK_EN defined, word3 = 16'h0011, run 64 v_sync pulses -> char pixels show fg for frames 0-31 and bg for frames 32-63, then fg again.
